// File: rtl/farrow_pkg.sv
// farrow_pkg: shared types and constants for the Farrow resampler phase control
package farrow_pkg;

    typedef enum logic {IDLE, EMIT} mu_state_t;

    // 2**f as an unsigned integer, the fixed-point value of 1.0 with f fraction bits
    function automatic int unsigned one(input int unsigned f);
        return 32'd1 << f;
    endfunction

    localparam int unsigned DEF_FRAC = 18;
    localparam int unsigned DEF_STEP = one(DEF_FRAC);

endpackage

// File: rtl/farrow_mu_ctrl.sv
// farrow_mu_ctrl: phase accumulator and strobe generator feeding mu to the Farrow datapath
module farrow_mu_ctrl
    import farrow_pkg::*;
#(
    parameter int wight_data  = 20,
    parameter int wight_delay = 18,
    parameter int int_bits    = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [wight_data-1:0]           data_in,
    input  logic                            vld_in,
    output logic                            rdy_in,
    input  logic [wight_delay+int_bits-1:0] step_in,
    input  logic                            step_wr,
    input  logic                            sync_clr,
    output logic [wight_data-1:0]           data_out,
    output logic [wight_delay-1:0]          delay,
    output logic                            vld_out
);

    localparam int W = wight_delay + int_bits;
    localparam logic [W:0] ONE = {{int_bits{1'b0}}, 1'b1, {wight_delay{1'b0}}};

    mu_state_t      state, nxt_state;
    logic [W-1:0]   acc, step, pend;
    logic           pend_vld;
    logic [W:0]     nxt, nxt_m1, acc_m1;
    logic           acc_ge_one, accept, done, step_ok;

    assign nxt        = {1'b0, acc} + {1'b0, step};
    assign nxt_m1     = nxt - ONE;
    assign acc_m1     = {1'b0, acc} - ONE;
    assign acc_ge_one = {1'b0, acc} >= ONE;
    assign accept     = vld_in & rdy_in;
    assign done       = state == EMIT && nxt >= ONE;
    assign step_ok    = step_wr && step_in != '0;
    assign delay      = acc[wight_delay-1:0];

    // state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : nxt_state;

    // next state: clear wins, IDLE enters EMIT on an accepted sample below ONE, EMIT leaves once the phase wraps
    always_comb
        nxt_state = sync_clr ? IDLE :
                    state == IDLE ? ((accept && !acc_ge_one) ? EMIT : IDLE) :
                    (done ? IDLE : EMIT);

    // handshake and strobe depend only on state, plus the clear blocking acceptance
    always_comb begin
        rdy_in  = state == IDLE && !sync_clr;
        vld_out = state == EMIT;
    end

    // phase accumulator: skip on decimation, advance by step per emitted output
    always_ff @(posedge clk)
        if (rst || sync_clr)
            acc <= '0;
        else if (state == EMIT)
            acc <= done ? nxt_m1[W-1:0] : nxt[W-1:0];
        else if (accept && acc_ge_one)
            acc <= acc_m1[W-1:0];

    // sample hold for the whole burst
    always_ff @(posedge clk)
        if (rst)
            data_out <= '0;
        else if (accept && !acc_ge_one)
            data_out <= data_in;

    // step update: immediate in IDLE, deferred to burst end or clear while emitting
    always_ff @(posedge clk)
        if (rst) begin
            step     <= ONE[W-1:0];
            pend     <= '0;
            pend_vld <= 1'b0;
        end else if (sync_clr || done) begin
            step     <= step_ok ? step_in : pend_vld ? pend : step;
            pend_vld <= 1'b0;
        end else if (state == EMIT) begin
            if (step_ok) begin
                pend     <= step_in;
                pend_vld <= 1'b1;
            end
        end else if (step_ok)
            step <= step_in;

endmodule

// File: tb/tb_farrow_mu_ctrl.sv
// tb_farrow_mu_ctrl: directed and random stimulus checked against a burst-level phase model
module tb_farrow_mu_ctrl;

    localparam int DW = 20;
    localparam int F  = 18;
    localparam int IB = 4;
    localparam int W  = F + IB;
    localparam int unsigned ONE = 32'd1 << F;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          vld_in = 1'b0;
    logic          rdy_in;
    logic [W-1:0]  step_in = '0;
    logic          step_wr = 1'b0;
    logic          sync_clr = 1'b0;
    logic [DW-1:0] data_out;
    logic [F-1:0]  delay;
    logic          vld_out;

    always #5 clk = ~clk;

    farrow_mu_ctrl #(.wight_data(DW), .wight_delay(F), .int_bits(IB)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .vld_in(vld_in), .rdy_in(rdy_in),
        .step_in(step_in), .step_wr(step_wr), .sync_clr(sync_clr),
        .data_out(data_out), .delay(delay), .vld_out(vld_out)
    );

    int checks = 0;
    int errors = 0;

    // reference: phase after the current burst, active step, pending step, queued mu values
    int unsigned   m_acc, m_step, m_pend;
    bit            m_pv;
    logic [DW-1:0] m_data;
    int unsigned   m_q[$];
    bit            last_acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_step = ONE; m_pend = 0; m_pv = 0; m_data = '0;
        m_q.delete();
    endtask

    task automatic cyc(input bit r, input bit v, input logic [DW-1:0] d,
                       input bit sw, input int unsigned s, input bit sc);
        int unsigned n;
        bit ok;
        @(negedge clk);
        rst = r; vld_in = v; data_in = d; step_wr = sw; step_in = W'(s); sync_clr = sc;
        #1;
        chk("vld_out", vld_out, m_q.size() != 0);
        chk("data_out", data_out, m_data);
        chk("delay", delay, m_q.size() != 0 ? m_q[0] : m_acc % ONE);
        if (!r) chk("rdy_in", rdy_in, m_q.size() == 0 && !sc);
        ok = !r && v && m_q.size() == 0 && !sc;
        last_acc = ok;
        if (r)
            model_reset();
        else if (sc) begin
            m_acc = 0;
            m_q.delete();
            if (m_pv) m_step = m_pend;
            m_pv = 0;
            if (sw && s != 0) m_step = s;
        end else if (m_q.size() != 0) begin
            void'(m_q.pop_front());
            if (sw && s != 0) begin m_pend = s; m_pv = 1; end
            if (m_q.size() == 0 && m_pv) begin m_step = m_pend; m_pv = 0; end
        end else begin
            if (sw && s != 0) m_step = s;
            if (ok) begin
                if (m_acc >= ONE)
                    m_acc -= ONE;
                else begin
                    m_data = d;
                    while (1) begin
                        m_q.push_back(m_acc);
                        n = m_acc + m_step;
                        if (n < ONE) m_acc = n;
                        else begin m_acc = n - ONE; break; end
                    end
                end
            end
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(0, 0, '0, 0, 0, 0);
    endtask

    task automatic set_step(input int unsigned s);
        cyc(0, 0, '0, 1, s, 0);
    endtask

    // hold a sample on the input until it is taken, bounded
    task automatic send(input logic [DW-1:0] d);
        for (int i = 0; i < 40; i++) begin
            cyc(0, 1, d, 0, 0, 0);
            if (last_acc) return;
        end
        chk("send_timeout", 0, 1);
    endtask

    function automatic int unsigned pick_step();
        case ($urandom_range(0, 5))
            0: return 0;
            1: return ONE;
            2: return ONE / 2;
            3: return 196608;
            4: return 2 * ONE;
            default: return $urandom_range(ONE / 8, (1 << W) - 1);
        endcase
    endfunction

    initial begin
        model_reset();
        cyc(1, 0, '0, 0, 0, 0);
        cyc(1, 0, '0, 0, 0, 0);
        idle(1);
        chk("reset_rdy", rdy_in, 1);
        chk("reset_vld", vld_out, 0);
        chk("reset_delay", delay, 0);
        chk("reset_data", data_out, 0);

        // unity ratio: one strobe per sample, mu 0
        set_step(ONE);
        for (int i = 0; i < 8; i++) send(DW'(100 + i));
        idle(1);
        chk("t1_delay", delay, 0);

        // x2 interpolation
        set_step(131072);
        for (int i = 0; i < 4; i++) send(DW'(200 + i));
        idle(2);

        // 3->4 interpolation; phase returns to zero after three samples
        cyc(0, 0, '0, 1, 196608, 1);
        for (int i = 0; i < 3; i++) send(DW'(300 + i));
        idle(2);
        chk("t3_acc_zero", delay, 0);

        // /2 decimation
        set_step(2 * ONE);
        for (int i = 0; i < 5; i++) send(DW'(400 + i));
        idle(2);

        // step change mid-burst, then a zero write that must be ignored
        cyc(0, 0, '0, 1, 65536, 1);
        send(DW'(500));
        cyc(0, 0, '0, 1, 131072, 0);
        cyc(0, 0, '0, 1, 0, 0);
        idle(3);
        send(DW'(501));
        send(DW'(502));
        set_step(0);
        send(DW'(503));
        idle(3);

        // sync_clr mid-burst with a sample offered, then reset mid-burst
        set_step(65536);
        send(DW'(600));
        cyc(0, 1, DW'(601), 0, 0, 1);
        chk("t6_not_taken", last_acc, 0);
        idle(1);
        chk("t6_vld_low", vld_out, 0);
        send(DW'(602));
        chk("t6_mu0", delay, 0);
        cyc(0, 0, '0, 0, 0, 0);
        cyc(1, 0, '0, 0, 0, 0);
        idle(1);
        chk("t6_rst_data", data_out, 0);
        chk("t6_rst_vld", vld_out, 0);

        // random traffic
        for (int i = 0; i < 4000; i++)
            cyc($urandom_range(0, 599) == 0, $urandom_range(0, 3) != 0, DW'($urandom),
                $urandom_range(0, 11) == 0, pick_step(), $urandom_range(0, 79) == 0);
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
